// File: rtl/float_add.sv
// Pipelined binary32 adder: operand register, align/add stage, normalise/round stage.
// FLOAT_ADD_RNE_EN selects round-to-nearest-even; otherwise results truncate toward zero.
module float_add (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] float_a,
  input  logic [31:0] float_b,
  output logic        out_valid,
  output logic [31:0] sum
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic        spec;
    logic [31:0] spec_val;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;   // {carry, hidden, fraction[22:0], guard, round, sticky}
  } s1_t;

  logic [STAGES:0] vld_pipe_q;
  logic [31:0]     a_q, b_q;
  s1_t             s1_d, s1_q;
  logic [31:0]     sum_d, sum_q;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  // ---------------- stage 1: unpack, classify, align, add ----------------
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
  logic [7:0]  big_e, sml_e, diff;
  logic [23:0] big_m, sml_m;
  logic [49:0] ext;
  logic [26:0] big27, sml27;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;

  always_comb begin
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);

    a_big = (a_q[30:0] >= b_q[30:0]);
    big_e = a_big ? ea : eb;
    sml_e = a_big ? eb : ea;
    big_m = {1'b1, a_big ? fa : fb};
    sml_m = {1'b1, a_big ? fb : fa};
    diff  = big_e - sml_e;
    ext   = {sml_m, 26'd0} >> diff;
    // Past 25 positions nothing reaches the round bit; only stickiness remains.
    sml27 = (diff >= 8'd26) ? 27'd1 : {ext[49:24], |ext[23:0]};
    big27 = {big_m, 3'b000};

    s1_d          = '0;
    s1_d.sign     = a_big ? sa : sb;
    s1_d.exp      = big_e;
    s1_d.mant     = (sa ^ sb) ? ({1'b0, big27} - {1'b0, sml27})
                              : ({1'b0, big27} + {1'b0, sml27});
    s1_d.spec     = 1'b1;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) s1_d.spec_val = 32'h7FC00000;
    else if (a_inf)             s1_d.spec_val = a_q;
    else if (b_inf)             s1_d.spec_val = b_q;
    else if (a_zero && b_zero)  s1_d.spec_val = {sa & sb, 31'd0};
    else if (a_zero)            s1_d.spec_val = b_q;
    else if (b_zero)            s1_d.spec_val = a_q;
    else                        s1_d.spec     = 1'b0;
  end

  // ---------------- stage 2: normalise, round, pack ----------------
  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] exp_n, exp_r;
  logic              inc;
  logic [24:0]       rnd;
  logic [22:0]       frac;

  always_comb begin
    lz = lzc27(s1_q.mant[26:0]);
    if (s1_q.mant[27]) begin
      norm  = {s1_q.mant[27:2], s1_q.mant[1] | s1_q.mant[0]};
      exp_n = $signed({2'b00, s1_q.exp}) + 10'sd1;
    end else begin
      norm  = s1_q.mant[26:0] << lz;
      exp_n = $signed({2'b00, s1_q.exp}) - $signed({5'd0, lz});
    end
`ifdef FLOAT_ADD_RNE_EN
    inc = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
    inc = 1'b0;
`endif
    rnd   = {1'b0, norm[26:3]} + {24'd0, inc};
    exp_r = exp_n + $signed({9'd0, rnd[24]});
    frac  = rnd[24] ? rnd[23:1] : rnd[22:0];

    if (s1_q.spec)                          sum_d = s1_q.spec_val;
    else if (norm == '0 || exp_r <= 10'sd0) sum_d = 32'd0;
    else if (exp_r >= 10'sd255)             sum_d = {s1_q.sign, 8'hFF, 23'd0};
    else                                    sum_d = {s1_q.sign, exp_r[7:0], frac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s1_q       <= '0;
      sum_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], in_valid};
      a_q        <= float_a;
      b_q        <= float_b;
      s1_q       <= s1_d;
      if (vld_pipe_q[1]) sum_q <= sum_d;
    end
  end

  assign out_valid = vld_pipe_q[STAGES];
  assign sum       = sum_q;
endmodule

// File: tb/tb_float_add.sv
// Bench for float_add: directed vectors, back-to-back, randomized against an exact-integer model, async reset.
module tb_float_add;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] float_a, float_b;
  logic        out_valid;
  logic [31:0] sum;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  float_add dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .float_a(float_a), .float_b(float_b),
    .out_valid(out_valid), .sum(sum)
  );

  // Exact sum as a scaled integer, then a single rounding to 24 significant bits.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic   sa, sb, sg;
    int     ea, eb, s, base, p, e;
    longint va, vb, v, mag, q;
    sa = a[31]; sb = b[31]; ea = int'(a[30:23]); eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC00000 : a;
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
    if (ea == 0) return b;
    if (eb == 0) return a;
    va = longint'({1'b1, a[22:0]});
    vb = longint'({1'b1, b[22:0]});
    if (ea >= eb) begin
      s = ea - eb;
      if (s > 36) begin vb = 1; s = 36; end
      va = va << s; base = ea - s;
    end else begin
      s = eb - ea;
      if (s > 36) begin va = 1; s = 36; end
      vb = vb << s; base = eb - s;
    end
    v = (sa ? -va : va) + (sb ? -vb : vb);
    if (v == 0) return 32'd0;
    sg  = (v < 0);
    mag = sg ? -v : v;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    e = p + base - 23;
    if (p > 23) begin
      q = mag >> (p - 23);
`ifdef FLOAT_ADD_RNE_EN
      begin
        longint rem, half;
        rem  = mag - (q << (p - 23));
        half = longint'(1) << (p - 24);
        if (rem > half || (rem == half && q[0])) q = q + 1;
      end
`endif
    end else begin
      q = mag << (23 - p);
    end
    if (q == (longint'(1) << 24)) begin q = q >> 1; e = e + 1; end
    if (e <= 0) return 32'd0;
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    return {sg, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] near);
    logic [31:0] r;
    int k, e;
    r = $urandom;
    k = $urandom_range(0, 19);
    case (k)
      0: r[30:0] = 31'd0;
      1: r[30:0] = {8'hFF, 23'd0};
      2: r[30:23] = 8'hFF;
      3: r[30:23] = 8'h00;
      4: r = {~near[31], near[30:0]};
      5: r = {~near[31], near[30:1], ~near[0]};
      default: begin
        e = int'(near[30:23]) + $urandom_range(0, 60) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        r[30:23] = e[7:0];
      end
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; float_a = '0; float_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid out_valid=%b expected 0", out_valid); end
    checks++;
    if (sum !== 32'd0) begin errors++; $display("FAIL reset_sum sum=%h expected 00000000", sum); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    localparam int N = 11;
    logic [31:0] va[N], vb[N], ve[N];
    va = '{32'hBAB1CF4B, 32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h7F800000, 32'h7F7FFFFF,
           32'h7FC00000, 32'h80000000, 32'h3F800000, 32'h00000001, 32'h00800001};
    vb = '{32'h3AAAAD74, 32'h3F800000, 32'hBF800000, 32'h33800000, 32'hFF800000, 32'h7F7FFFFF,
           32'h3F800000, 32'h80000000, 32'h7F800000, 32'h3F800000, 32'h80800000};
    ve = '{32'hB8643AE0, 32'h40000000, 32'h00000000,
`ifdef FLOAT_ADD_RNE_EN
           32'h3F800002,
`else
           32'h3F800001,
`endif
           32'h7FC00000, 32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h3F800000,
           32'h00000000};
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== ve[i-3]) begin
          errors++;
          $display("FAIL directed[%0d] %h+%h: out_valid=%b sum=%h expected out_valid=1 sum=%h",
                   i - 3, va[i-3], vb[i-3], out_valid, sum, ve[i-3]);
        end
      end
      if (i < N) begin in_valid = 1'b1; float_a = va[i]; float_b = vb[i]; end
      else in_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic        vv[N];
    logic [31:0] va[N], vb[N], ve[N];
    logic [31:0] last;
    vv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    va = '{32'h39D844D0, 32'h00000000, 32'h12345678, 32'h0, 32'h3F800000, 32'h0};
    vb = '{32'h00000000, 32'h39D844D0, 32'h12345678, 32'h0, 32'h3F800000, 32'h0};
    ve = '{32'h39D844D0, 32'h39D844D0, 32'h0, 32'h0, 32'h40000000, 32'h0};
    last = '0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        checks++;
        if (vv[i-3]) begin
          if (out_valid !== 1'b1 || sum !== ve[i-3]) begin
            errors++;
            $display("FAIL b2b[%0d]: out_valid=%b sum=%h expected out_valid=1 sum=%h",
                     i - 3, out_valid, sum, ve[i-3]);
          end
          last = ve[i-3];
        end else if (out_valid !== 1'b0 || sum !== last) begin
          errors++;
          $display("FAIL b2b_idle[%0d]: out_valid=%b sum=%h expected out_valid=0 sum=%h",
                   i - 3, out_valid, sum, last);
        end
      end
      if (i < N) begin in_valid = vv[i]; float_a = va[i]; float_b = vb[i]; end
      else in_valid = 1'b0;
    end
  endtask

  task automatic test_random();
    localparam int N = 300;
    logic        vv[N];
    logic [31:0] va[N], vb[N], ve[N];
    logic [31:0] last;
    for (int i = 0; i < N; i++) begin
      vv[i] = (i == 0) || ($urandom_range(0, 3) != 0);
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        va[i] = vb[i-1]; vb[i] = va[i-1];
      end else begin
        va[i] = $urandom;
        if ($urandom_range(0, 15) == 0) va[i][30:23] = 8'd254;
        vb[i] = rand_op(va[i]);
      end
      ve[i] = ref_add(va[i], vb[i]);
    end
    last = '0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        checks++;
        if (vv[i-3]) begin
          if (out_valid !== 1'b1 || sum !== ve[i-3]) begin
            errors++;
            $display("FAIL random[%0d] %h+%h: out_valid=%b sum=%h expected out_valid=1 sum=%h",
                     i - 3, va[i-3], vb[i-3], out_valid, sum, ve[i-3]);
          end
          last = ve[i-3];
        end else if (out_valid !== 1'b0 || sum !== last) begin
          errors++;
          $display("FAIL random_idle[%0d]: out_valid=%b sum=%h expected out_valid=0 sum=%h",
                   i - 3, out_valid, sum, last);
        end
      end
      if (i < N) begin in_valid = vv[i]; float_a = va[i]; float_b = vb[i]; end
      else in_valid = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); in_valid = 1'b1; float_a = 32'h3F800000; float_b = 32'h3F800000;
    @(negedge clk); float_a = 32'hBAB1CF4B; float_b = 32'h3AAAAD74;
    @(negedge clk); float_a = 32'h40400000; float_b = 32'h3F800000;
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sum !== 32'h40000000) begin
      errors++;
      $display("FAIL rst_pre: out_valid=%b sum=%h expected out_valid=1 sum=40000000", out_valid, sum);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 32'd0) begin
      errors++;
      $display("FAIL rst_async: out_valid=%b sum=%h expected out_valid=0 sum=00000000", out_valid, sum);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || sum !== 32'd0) begin
        errors++;
        $display("FAIL rst_no_pulse[%0d]: out_valid=%b sum=%h expected out_valid=0 sum=00000000",
                 i, out_valid, sum);
      end
    end
    in_valid = 1'b1; float_a = 32'h40400000; float_b = 32'h3F800000;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_latency_early: out_valid=%b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || sum !== 32'h40800000) begin
      errors++;
      $display("FAIL rst_after: out_valid=%b sum=%h expected out_valid=1 sum=40800000", out_valid, sum);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/float_add.md
Name: float_add

Overview:
- Pipelined IEEE-754 single-precision floating-point adder for the CNN datapath: computes sum = float_a + float_b.
- Accepts one operand pair per clock and delivers each result exactly 2 cycles later, with a valid flag travelling alongside the data.
- Used for partial-sum accumulation in convolution and fully-connected layers.

Parameters:
- None. Format is fixed at 32-bit binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clk  input  1  rising-edge clock; the block uses only this clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  float_a/float_b hold a new operand pair this cycle.
- float_a  input  32  operand A (binary32).
- float_b  input  32  operand B (binary32).
- out_valid  output  1  sum holds a new result.
- sum  output  32  A+B (binary32), registered.

Behaviour:
- Reset: when rst_n is low, all pipeline registers, out_valid and sum clear to 0 immediately, without waiting for a clock edge. Release is synchronous to clk.
- Reset mid-operation discards every in-flight result; no out_valid pulse is produced for pairs accepted before reset.
- Latency:
  - An operand pair sampled with in_valid=1 at edge N appears on sum with out_valid=1 after edge N+2.
  - Throughput is 1 pair per cycle; there is no stall or backpressure.
- When in_valid=0, the pipeline still advances. out_valid drops 2 cycles later, and sum holds its last value while out_valid=0.
- Stage 1, unpack and align:
  - Restore the hidden bit.
  - Swap operands so the larger magnitude (exponent first, then mantissa) is the big operand.
  - Right-shift the small mantissa by the exponent difference, keeping guard, round and sticky bits; a shift of 26 or more reduces it to sticky only.
  - Add the mantissas if the signs are equal, otherwise subtract.
  - Result sign = sign of the larger-magnitude operand.
- Stage 2, normalise and round:
  - On carry-out, shift right by 1 and increment the exponent.
  - Otherwise, leading-zero count, shift left and decrement the exponent.
  - Round per the Optional Feature, renormalise if rounding carries out, then pack.
- Special cases (decided):
  - Denormal inputs (exp=0) are treated as ±0.
  - A result whose exponent is ≤0 is flushed to +0.
  - Exact cancellation (x + −x) returns +0 (0x00000000).
  - 0 + x returns x bit-exact; −0 + −0 returns 0x80000000.
  - Any NaN input, or +Inf + −Inf, returns the canonical NaN 0x7FC00000.
  - Inf + finite returns that Inf.
  - Exponent overflow (≥255) returns ±Inf (0x7F800000 / 0xFF800000).
- The operation is commutative: swapping float_a and float_b yields an identical sum.

Optional Feature:
- Macro FLOAT_ADD_RNE_EN.
- Defined: round-to-nearest, ties-to-even, using guard/round/sticky bits.
- Undefined: round toward zero (truncate guard/round/sticky). This uses fewer LUTs and has a shorter stage-2 path.
- Latency, special-case handling and ports are identical in both builds.

Test Plan:
- Cancellation: in_valid=1, float_a=0xBAB1CF4B, float_b=0x3AAAAD74 -> two cycles later out_valid=1, sum=0xB8643AE0 (exact, same in both builds).
- Zero operand: float_a=0x39D844D0, float_b=0x00000000 -> sum=0x39D844D0. Swapped operands give the same result. Both pairs issued back-to-back -> results on consecutive cycles.
- Normal add: 0x3F800000 + 0x3F800000 -> 0x40000000. 0x3F800000 + 0xBF800000 -> 0x00000000.
- Rounding tie: 0x3F800001 + 0x33800000 -> 0x3F800002 with FLOAT_ADD_RNE_EN, 0x3F800001 without.
- Specials: 0x7F800000 + 0xFF800000 -> 0x7FC00000. 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000. 0x7FC00000 + 0x3F800000 -> 0x7FC00000.
- Reset: assert rst_n=0 asynchronously, between clock edges, with two pairs in flight -> sum=0 and out_valid=0 immediately, with no later out_valid pulse. After release, a new pair returns its correct result 2 cycles later.
